// File: rtl/syncnt_down_load.sv
// Loadable down-counter / one-shot timer: counts a loaded value down to zero, then flags tc.
// Optional periodic reload from a stored load value when SYNCNT_AUTORELOAD_EN is defined.
module syncnt_down_load #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         zero,
  output logic         busy,
  output logic         tc
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state, state_n;
  logic [W-1:0] q_n;

`ifdef SYNCNT_AUTORELOAD_EN
  logic [W-1:0] rl;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)     rl <= '0;
    else if (load) rl <= d;
  end
`endif

  always_comb begin
    state_n = state;
    q_n     = q;
    if (load) begin
      q_n     = d;
      state_n = (d != '0) ? RUN : IDLE;
    end else begin
      unique case (state)
        IDLE: ;
        RUN: begin
          if (en) begin
            // q<=1 covers the never-expected q==0 in RUN without underflowing
            if (q <= ONE) begin
              q_n     = '0;
              state_n = DONE;
            end else begin
              q_n = q - ONE;
            end
          end
        end
        DONE: begin
`ifdef SYNCNT_AUTORELOAD_EN
          if (en) begin
            q_n     = rl;
            state_n = (rl != '0) ? RUN : IDLE;
          end
`else
          state_n = IDLE;
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // busy/tc are registered copies of the next-state decode so they leave flops directly
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      q     <= '0;
      busy  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      busy  <= (state_n == RUN);
      tc    <= (state_n == DONE);
    end
  end

  assign zero = (q == '0);

endmodule

// File: tb/tb_syncnt_down_load.sv
// Directed self-checking bench for syncnt_down_load (W=3); autoreload checks build only
// when SYNCNT_AUTORELOAD_EN is defined.
module tb_syncnt_down_load;

  logic       clk = 1'b0;
  logic       nrst;
  logic       en;
  logic       load;
  logic [2:0] d;
  logic [2:0] q;
  logic       zero, busy, tc;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  syncnt_down_load #(.W(3)) dut (
    .clk  (clk),
    .nrst (nrst),
    .en   (en),
    .load (load),
    .d    (d),
    .q    (q),
    .zero (zero),
    .busy (busy),
    .tc   (tc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b1; load = 1'b0; d = 3'd0;
    #3;
    vectors++;
    if ({q, zero, busy, tc} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async: got q=%0d zero=%b busy=%b tc=%b, want q=0 zero=1 busy=0 tc=0", q, zero, busy, tc);
    end
    tick();
    nrst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({q, zero, busy, tc} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL idle_en[%0d]: got q=%0d zero=%b busy=%b tc=%b, want q=0 zero=1 busy=0 tc=0", i, q, zero, busy, tc);
      end
    end
  endtask

  task automatic test_countdown();
    // expected {q, zero, busy, tc} after each edge, first entry is the load edge
    logic [5:0] exp [8] = '{
      {3'd5, 3'b010}, {3'd4, 3'b010}, {3'd3, 3'b010}, {3'd2, 3'b010},
      {3'd1, 3'b010}, {3'd0, 3'b101}, {3'd0, 3'b100}, {3'd0, 3'b100}};
    load = 1'b1; d = 3'd5; en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      load = 1'b0; en = 1'b1;
      vectors++;
      if ({q, zero, busy, tc} !== exp[i]) begin
        miscompares++;
        $display("FAIL countdown[%0d]: got q=%0d zero=%b busy=%b tc=%b, want %b", i, q, zero, busy, tc, exp[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_enable_gaps();
    logic       pat  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] exp  [5] = '{{3'd2, 2'b10}, {3'd2, 2'b10}, {3'd2, 2'b10}, {3'd1, 2'b10}, {3'd0, 2'b01}};
    load = 1'b1; d = 3'd3; en = 1'b0;
    tick();
    load = 1'b0;
    vectors++;
    if ({q, busy, tc} !== {3'd3, 2'b10}) begin
      miscompares++;
      $display("FAIL gaps_load: got q=%0d busy=%b tc=%b, want q=3 busy=1 tc=0", q, busy, tc);
    end
    for (int i = 0; i < 5; i++) begin
      en = pat[i];
      tick();
      vectors++;
      if ({q, busy, tc} !== exp[i]) begin
        miscompares++;
        $display("FAIL gaps[%0d]: got q=%0d busy=%b tc=%b, want %b", i, q, busy, tc, exp[i]);
      end
    end
    en = 1'b0;
    tick();
    vectors++;
    if ({q, busy, tc} !== {3'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL gaps_idle: got q=%0d busy=%b tc=%b, want q=0 busy=0 tc=0", q, busy, tc);
    end
  endtask

  task automatic test_load_priority();
    load = 1'b1; d = 3'd4; en = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    vectors++;
    if ({q, busy} !== {3'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL prio_pre: got q=%0d busy=%b, want q=2 busy=1", q, busy);
    end
    load = 1'b1; d = 3'd7; en = 1'b1;
    tick();
    vectors++;
    if ({q, busy, tc} !== {3'd7, 2'b10}) begin
      miscompares++;
      $display("FAIL prio_reload: got q=%0d busy=%b tc=%b, want q=7 busy=1 tc=0", q, busy, tc);
    end
    d = 3'd0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({q, zero, busy, tc} !== {3'd0, 3'b100}) begin
        miscompares++;
        $display("FAIL load_zero[%0d]: got q=%0d zero=%b busy=%b tc=%b, want q=0 zero=1 busy=0 tc=0", i, q, zero, busy, tc);
      end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; d = 3'd6; en = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    vectors++;
    if ({q, busy} !== {3'd4, 1'b1}) begin
      miscompares++;
      $display("FAIL areset_pre: got q=%0d busy=%b, want q=4 busy=1", q, busy);
    end
    #1 nrst = 1'b0;
    #1;
    vectors++;
    if ({q, zero, busy, tc} !== {3'd0, 3'b100}) begin
      miscompares++;
      $display("FAIL areset_now: got q=%0d zero=%b busy=%b tc=%b, want q=0 zero=1 busy=0 tc=0", q, zero, busy, tc);
    end
    #1 nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({q, busy, tc} !== {3'd0, 2'b00}) begin
        miscompares++;
        $display("FAIL areset_hold[%0d]: got q=%0d busy=%b tc=%b, want q=0 busy=0 tc=0", i, q, busy, tc);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_max_count();
    int unsigned first_tc = 0;
    load = 1'b1; d = 3'd7; en = 1'b1;
    tick();
    load = 1'b0;
    for (int unsigned i = 1; i <= 9; i++) begin
      tick();
      if (tc === 1'b1 && first_tc == 0) first_tc = i;
    end
    vectors++;
    if (first_tc != 7) begin
      miscompares++;
      $display("FAIL max_tc_cycle: got tc at enabled cycle %0d, want 7", first_tc);
    end
    vectors++;
    if ({q, busy, tc} !== {3'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL max_end: got q=%0d busy=%b tc=%b, want q=0 busy=0 tc=0", q, busy, tc);
    end
    en = 1'b0;
  endtask

`ifdef SYNCNT_AUTORELOAD_EN
  task automatic test_autoreload();
    logic [4:0] exp [6] = '{{3'd1, 2'b10}, {3'd0, 2'b01}, {3'd2, 2'b10},
                            {3'd1, 2'b10}, {3'd0, 2'b01}, {3'd2, 2'b10}};
    load = 1'b1; d = 3'd2; en = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if ({q, busy, tc} !== exp[i]) begin
        miscompares++;
        $display("FAIL reload[%0d]: got q=%0d busy=%b tc=%b, want %b", i, q, busy, tc, exp[i]);
      end
    end
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({q, busy, tc} !== {3'd0, 2'b01}) begin
        miscompares++;
        $display("FAIL done_hold[%0d]: got q=%0d busy=%b tc=%b, want q=0 busy=0 tc=1", i, q, busy, tc);
      end
    end
    en = 1'b1;
    tick();
    vectors++;
    if ({q, busy, tc} !== {3'd2, 2'b10}) begin
      miscompares++;
      $display("FAIL done_resume: got q=%0d busy=%b tc=%b, want q=2 busy=1 tc=0", q, busy, tc);
    end
    load = 1'b1; d = 3'd0;
    tick();
    load = 1'b0; en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_countdown();
    test_enable_gaps();
    test_load_priority();
    test_async_reset();
    test_max_count();
`ifdef SYNCNT_AUTORELOAD_EN
    test_autoreload();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
